// File: rtl/cache_line_ctrl.sv
// Memory-side line controller: writes back a dirty victim, refills the missing line
// over a word-wide req/ack port, and pulses update so the cache installs it.
module cache_line_ctrl #(
  parameter int BLOCK_WORDS = 4,
  parameter int LINE_OFFSET = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        cpu_req,
  input  logic                        miss,
  input  logic [31:0]                 cpu_addr,
  input  logic                        victim_dirty,
  input  logic [31:0]                 victim_addr,
  input  logic [BLOCK_WORDS-1:0][31:0] victim_words,
  output logic                        stall,
  output logic                        update,
  output logic [BLOCK_WORDS-1:0][31:0] fill_words,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_ack,
  input  logic [31:0]                 mem_rdata,
  output logic [31:0]                 fill_count,
  output logic [31:0]                 wb_count
);

  localparam int BEAT_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int LINE_W = 32 - LINE_OFFSET;
  localparam int PAD_W  = LINE_OFFSET - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, UPD} state_t;

  state_t                        state, state_n;
  logic [BEAT_W-1:0]             beat, beat_n;
  logic [LINE_W-1:0]             wb_line, wb_line_n, fill_line, fill_line_n;
  logic [BLOCK_WORDS-1:0][31:0]  wb_words, wb_words_n;
  logic                          capture, ack, last;
  logic                          unused_low_bits;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [LINE_W-1:0] line,
                                            input logic [BEAT_W-1:0] b);
    return {line, b, {PAD_W{1'b0}}};
  endfunction

  assign capture = (state == IDLE) && cpu_req && miss;
  assign ack     = mem_req && mem_ack;
  assign last    = (beat == LAST_BEAT);
  assign stall   = (state != IDLE) || (cpu_req && miss);
  assign unused_low_bits = ^{cpu_addr[LINE_OFFSET-1:0], victim_addr[LINE_OFFSET-1:0]};

  always_comb begin
    state_n     = state;
    beat_n      = beat;
    wb_line_n   = capture ? victim_addr[31:LINE_OFFSET] : wb_line;
    fill_line_n = capture ? cpu_addr[31:LINE_OFFSET] : fill_line;
    wb_words_n  = capture ? victim_words : wb_words;
    case (state)
      IDLE: begin
        if (cpu_req && miss) begin
          state_n = victim_dirty ? WB : FILL;
          beat_n  = '0;
        end
      end
      WB: begin
        if (ack) begin
          if (last) begin
            state_n = FILL;
            beat_n  = '0;
          end else begin
            beat_n = beat + BEAT_W'(1);
          end
        end
      end
      FILL: begin
        if (ack) begin
          if (last) begin
            state_n = UPD;
            beat_n  = '0;
          end else begin
            beat_n = beat + BEAT_W'(1);
          end
        end
      end
      UPD:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
    end
  end

  // Memory port is registered from the next state so a beat is presented the
  // same cycle the FSM enters WB/FILL and holds until acknowledged.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      update     <= 1'b0;
      fill_words <= '0;
      fill_count <= '0;
      wb_count   <= '0;
    end else begin
      mem_req   <= (state_n == WB) || (state_n == FILL);
      mem_we    <= (state_n == WB);
      update    <= (state_n == UPD);
      mem_wdata <= (state_n == WB) ? wb_words_n[beat_n] : 32'd0;
      case (state_n)
        WB:      mem_addr <= beat_addr(wb_line_n, beat_n);
        FILL:    mem_addr <= beat_addr(fill_line_n, beat_n);
        default: mem_addr <= '0;
      endcase
      if (state == FILL && ack) fill_words[beat] <= mem_rdata;
      if (state == FILL && ack && last) fill_count <= sat_inc(fill_count);
      if (state == WB && ack && last) wb_count <= sat_inc(wb_count);
    end
  end

  // Line registers are pure data, loaded only when a miss is accepted.
  always_ff @(posedge CLK) begin
    wb_line   <= wb_line_n;
    fill_line <= fill_line_n;
    wb_words  <= wb_words_n;
  end

endmodule

// File: doc/cache_line_ctrl.md
Name: cache_line_ctrl

Overview:
- Memory-side controller for the set-associative data cache; the responder to the cache's miss/writeback requests.
- On a CPU access that misses, stalls the CPU and writes back the dirty victim line (4 words) if needed.
- Then fetches the missing line (4 words) over a word-wide req/ack memory port and pulses update so the cache installs the line.
- Keeps 32-bit saturating counters of fills and writebacks for performance runs.

Parameters:
- BLOCK_WORDS, 4, words per cache line; beat counter width is clog2(BLOCK_WORDS).
- LINE_OFFSET, 4, byte-offset bits per line (addr[3:0]).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST_N  input  1  reset, asynchronous, active-low.
- cpu_req  input  1  CPU issues a load/store this cycle.
- miss  input  1  cache miss for the current address.
- cpu_addr  input  32  CPU byte address of the access.
- victim_dirty  input  1  the LRU way of the indexed set is dirty.
- victim_addr  input  32  line-aligned address of the LRU victim.
- victim_words  input  32 x4  victim line data, word 0..3.
- stall  output  1  hold the CPU pipeline.
- update  output  1  one-cycle pulse; cache installs fill_words.
- fill_words  output  32 x4  assembled refill line.
- mem_req  output  1  memory beat request.
- mem_we  output  1  1 = write beat, 0 = read beat.
- mem_addr  output  32  word address of the current beat.
- mem_wdata  output  32  write data of the current beat.
- mem_ack  input  1  memory completes the current beat.
- mem_rdata  input  32  read data; valid in the mem_ack cycle.
- fill_count  output  32  completed refills, saturating.
- wb_count  output  32  completed writebacks, saturating.

Behaviour:
- Reset (async, RST_N=0): state IDLE, beat=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, update=0, fill_words all 0, both counters 0. Reset mid-burst abandons the burst with no further beats.
- Registered datapath; stall is combinational: stall = (state!=IDLE) || (cpu_req && miss). Stalls in the same cycle the miss is seen.
- IDLE:
  - cpu_req && miss && victim_dirty -> WB. Capture victim_addr[31:4], victim_words[0..3], cpu_addr[31:4] into line registers.
  - cpu_req && miss && !victim_dirty -> FILL. Capture cpu_addr[31:4].
  - miss without cpu_req is ignored.
- WB: mem_req=1, mem_we=1, mem_addr={victim_line, beat, 2'b00}, mem_wdata=captured word[beat].
  - Outputs are held stable until mem_ack is sampled high.
  - On ack: beat++. On ack of beat 3: beat=0, wb_count++ (saturating at 0xFFFFFFFF), -> FILL.
- FILL: mem_req=1, mem_we=0, mem_addr={fill_line, beat, 2'b00}.
  - On ack: fill_words[beat] <= mem_rdata, beat++.
  - On ack of beat 3: fill_count++ (saturating), -> UPD.
- UPD: update=1 for exactly one cycle; mem_req=0; fill_words stable. -> IDLE.
  - The cache writes on the negedge within this cycle.
  - The retried access hits in IDLE next cycle, and stall drops then.
- mem_req deasserts in the cycle after the final ack. Between non-final beats mem_req stays high; back-to-back acks give 1 beat/cycle.
- mem_ack while mem_req=0 is ignored.
- Minimum miss latency: clean miss = 4 beats + UPD + 1 = 6 cycles of stall; dirty = 10.
- Writeback always completes before any read of the fill line, so a victim in the same line as the fill can never return stale data.
- cpu_addr and miss changes during a non-IDLE state are ignored; the captured line registers are used.

Test Plan:
- Clean miss, cpu_addr=0x0000_1234, victim_dirty=0, mem_ack every cycle:
  - mem reads at 0x1230, 0x1234, 0x1238, 0x123C.
  - update pulses 1 cycle after the last ack, with fill_words = rdata beats in order.
  - stall high 6 cycles; fill_count=1, wb_count=0.
- Dirty miss, victim_addr=0x0000_0040, victim_words={A0,A1,A2,A3}:
  - writes A0..A3 to 0x40..0x4C first, then reads of the fill line.
  - wb_count=1, fill_count=1.
- Memory latency of 3 cycles per beat:
  - mem_req/mem_addr/mem_wdata stay constant through the wait cycles.
  - exactly 4 beats are issued; fill_words correct.
- Spurious mem_ack in IDLE, and miss with cpu_req=0:
  - no state change, stall=0, counters unchanged.
- RST_N asserted low mid-FILL after beat 1:
  - mem_req=0 immediately and asynchronously; state IDLE; fill_words=0.
  - the next miss restarts at beat 0.
- Counter saturation: preload wb_count/fill_count to 0xFFFFFFFF (force), run a dirty miss -> both remain 0xFFFFFFFF.
